rle_image_decompressor: RTL and testbench

- Expands the run-length-compressed binary image that arrives one 16-bit word at a time on Din while load=1 and cnn=0.
- Packs the decoded pixels 16 per word and writes them to the shared parameter/image RAM.
- Sits directly downstream of the coordinator's Din capture and upstream of the RAM write port.
- Guarantees each compressed word is fully consumed within 34 clock cycles, which is the fixed input pacing.

---
 rtl/rle_image_decompressor_if.sv | 36 +++
 rtl/rle_image_decompressor.sv | 173 +++++++++++++++++
 tb/tb_rle_image_decompressor.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_image_decompressor_if.sv
// Stream-in / RAM-write bundle for the RLE image decompressor.
//
// Handshake: a compressed word on in_data transfers on a rising clk edge
// where in_valid and in_ready are both high. The producer may raise
// in_valid at any time and holds in_data stable until the transfer.
// in_ready depends only on the consumer's own state, never on in_valid.
// ram_we is a single-cycle write strobe qualifying ram_addr/ram_data. The
// RAM port never back-pressures.
//
// Signals:
//   in_data  [15:8] zero-run length, [7:0] one-run length
//   in_valid producer has a word
//   in_ready consumer can take a word this cycle
//   ram_addr write address
//   ram_data 16 packed pixels, LSB first
//   ram_we   write strobe
interface rle_image_decompressor_if #(
  parameter int ADDR_W = 16
) ();
  logic [15:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              ram_we;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_addr, ram_data, ram_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/rle_image_decompressor.sv
// Run-length image decompressor. Each accepted word holds a zero run and a
// one run. Pixels are emitted one per cycle, packed 16 per RAM word (LSB
// first) and written from base_addr upward until IMG_PIXELS are decoded.
//
// Ports:
//   clk, RST   clock and asynchronous active-high reset
//   enable     image-load window; its rising edge starts a new image
//   base_addr  first RAM word, sampled on the enable rising edge
//   bus        compressed-word input and RAM write port (slave side)
//   pix_count  pixels decoded so far (saturates at IMG_PIXELS)
//   done       image complete, held until enable falls
//   err        sticky: a run was clamped or pixels were dropped
//   dbgState   current FSM state
module rle_image_decompressor #(
  parameter int IMG_PIXELS = 784,
  parameter int RUN_MAX    = 16,
  parameter int ADDR_W     = 16
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       enable,
  input  logic [ADDR_W-1:0]          base_addr,
  rle_image_decompressor_if.slave    bus,
  output logic [9:0]                 pix_count,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 dbgState
);

  localparam int              CW        = $clog2(RUN_MAX + 1);
  localparam logic [7:0]      RUN_MAX_B = 8'(RUN_MAX);
  localparam logic [CW-1:0]   RUN_MAX_C = CW'(RUN_MAX);
  localparam logic [CW-1:0]   ONE_C     = CW'(1);
  localparam logic [9:0]      LAST_PIX  = 10'(IMG_PIXELS - 1);

  typedef enum logic [2:0] {IDLE, ZEROS, ONES, FLUSH, DONE} state_t;

  state_t            state, stateNext;
  logic              enPrev;
  logic              enRise;
  logic [CW-1:0]     cnt0, cnt1;
  logic [3:0]        bitIdx;
  logic [15:0]       pack;
  logic [ADDR_W-1:0] ptr;

  logic [CW-1:0]     n0Clamp, n1Clamp;
  logic              clampHit;
  logic              inReady, accept, emit, pixVal;
  logic              lastPix, wordFull, runsLeft;
  logic [15:0]       pixMask;

  assign enRise = enable & ~enPrev;

  always_comb begin
    n0Clamp  = (bus.in_data[15:8] > RUN_MAX_B) ? RUN_MAX_C : bus.in_data[8 +: CW];
    n1Clamp  = (bus.in_data[7:0]  > RUN_MAX_B) ? RUN_MAX_C : bus.in_data[0 +: CW];
    clampHit = (bus.in_data[15:8] > RUN_MAX_B) || (bus.in_data[7:0] > RUN_MAX_B);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    accept    = 1'b0;
    emit      = 1'b0;
    pixVal    = 1'b0;
    lastPix   = 1'b0;
    wordFull  = 1'b0;
    runsLeft  = 1'b0;
    case (state)
      IDLE: begin
        // enPrev keeps in_ready low in the enable rising-edge cycle.
        inReady = enable & enPrev;
        accept  = inReady & bus.in_valid;
        if (accept) begin
          if (n0Clamp != '0)      stateNext = ZEROS;
          else if (n1Clamp != '0) stateNext = ONES;
        end
      end
      ZEROS, ONES: begin
        if (!enable) begin
          stateNext = IDLE;
        end else begin
          emit     = 1'b1;
          pixVal   = (state == ONES);
          lastPix  = (pix_count == LAST_PIX);
          wordFull = (bitIdx == 4'd15);
          runsLeft = (state == ZEROS) ? ((cnt0 > ONE_C) || (cnt1 != '0))
                                      : (cnt1 > ONE_C);
          // A full word on the final pixel is written directly; only a
          // partial word needs the FLUSH cycle.
          if (lastPix)               stateNext = wordFull ? DONE : FLUSH;
          else if (state == ZEROS) begin
            if (cnt0 == ONE_C)       stateNext = (cnt1 != '0) ? ONES : IDLE;
          end else if (cnt1 == ONE_C) stateNext = IDLE;
        end
      end
      FLUSH:   stateNext = enable ? DONE : IDLE;
      DONE:    if (!enable) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    pixMask = {15'd0, pixVal} << bitIdx;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      enPrev       <= 1'b0;
      cnt0         <= '0;
      cnt1         <= '0;
      bitIdx       <= '0;
      pack         <= '0;
      ptr          <= '0;
      pix_count    <= '0;
      err          <= 1'b0;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_data <= '0;
    end else begin
      enPrev     <= enable;
      bus.ram_we <= 1'b0;
      if (enRise) begin
        ptr       <= base_addr;
        pix_count <= '0;
        pack      <= '0;
        bitIdx    <= '0;
        err       <= 1'b0;
      end else if (!enable) begin
        // Abort: any partial word is discarded without a write.
        pack   <= '0;
        bitIdx <= '0;
      end else begin
        if (accept) begin
          cnt0 <= n0Clamp;
          cnt1 <= n1Clamp;
          if (clampHit) err <= 1'b1;
        end
        if (emit) begin
          if (state == ZEROS) cnt0 <= cnt0 - ONE_C;
          else                cnt1 <= cnt1 - ONE_C;
          pix_count <= pix_count + 10'd1;
          bitIdx    <= bitIdx + 4'd1;
          if (lastPix && runsLeft) err <= 1'b1;
          if (wordFull) begin
            bus.ram_we   <= 1'b1;
            bus.ram_addr <= ptr;
            bus.ram_data <= pack | pixMask;
            ptr          <= ptr + ADDR_W'(1);
            pack         <= '0;
          end else begin
            pack <= pack | pixMask;
          end
        end
        if (state == FLUSH) begin
          bus.ram_we   <= 1'b1;
          bus.ram_addr <= ptr;
          bus.ram_data <= pack;
          ptr          <= ptr + ADDR_W'(1);
          pack         <= '0;
          bitIdx       <= '0;
        end
      end
    end
  end

  assign bus.in_ready = inReady;
  assign done         = (state == DONE);
  assign dbgState     = state;

endmodule

// File: tb/tb_rle_image_decompressor.sv
// Self-checking bench for rle_image_decompressor: directed scenarios plus
// randomized images, checked against a pixel-stream model.
module tb_rle_image_decompressor;

  localparam int IMG = 784;
  localparam int RMAX = 16;

  // clock / reset
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic enable = 1'b0;
  logic [15:0] base_addr = '0;
  logic [9:0] pix_count;
  logic done, err;
  logic [2:0] dbgState;

  always #5 clk = ~clk;

  rle_image_decompressor_if #(.ADDR_W(16)) bus ();

  rle_image_decompressor #(.IMG_PIXELS(IMG), .RUN_MAX(RMAX), .ADDR_W(16)) dut (
    .clk(clk), .RST(RST), .enable(enable), .base_addr(base_addr),
    .bus(bus), .pix_count(pix_count), .done(done), .err(err),
    .dbgState(dbgState)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // model: pixel stream -> expected writes
  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];
  int          m_pix;
  bit          m_err;
  logic [15:0] m_pack;
  int          m_bits;
  logic [15:0] m_ptr;

  task automatic model_start(input logic [15:0] base);
    m_pix = 0; m_err = 0; m_pack = '0; m_bits = 0; m_ptr = base;
    exp_q.delete();
    wr_log.delete();
  endtask

  task automatic push_pix(input bit b);
    if (m_pix == IMG) begin
      m_err = 1;
      return;
    end
    m_pack[m_bits] = b;
    m_bits++;
    m_pix++;
    if (m_bits == 16) begin
      exp_q.push_back({m_ptr, m_pack});
      m_ptr++; m_pack = '0; m_bits = 0;
    end
  endtask

  function automatic int clampf(input int n);
    return (n > RMAX) ? RMAX : n;
  endfunction

  task automatic model_word(input logic [15:0] w);
    int n0, n1;
    n0 = int'(w[15:8]);
    n1 = int'(w[7:0]);
    if (n0 > RMAX || n1 > RMAX) m_err = 1;
    for (int i = 0; i < clampf(n0); i++) push_pix(1'b0);
    for (int i = 0; i < clampf(n1); i++) push_pix(1'b1);
    if (m_pix == IMG && m_bits != 0) begin
      exp_q.push_back({m_ptr, m_pack});
      m_ptr++; m_pack = '0; m_bits = 0;
    end
  endtask

  // scoreboard: every RAM write against the expected queue
  always @(negedge clk) begin
    if (!RST && bus.ram_we) begin
      wr_log.push_back({bus.ram_addr, bus.ram_data});
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %h, no write required", {bus.ram_addr, bus.ram_data});
      end else begin
        check("ram_write", {bus.ram_addr, bus.ram_data}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic start_image(input logic [15:0] base);
    @(negedge clk);
    enable = 1'b1;
    base_addr = base;
    model_start(base);
    @(negedge clk);
  endtask

  task automatic end_image();
    settle();
    check("exp_q_drained", exp_q.size(), 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("done_cleared", done, 1'b0);
    @(negedge clk);
  endtask

  // returns 1 once the word has transferred
  task automatic accept_only(input logic [15:0] w, output bit ok);
    int t;
    ok = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = w;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_word(w);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data = 16'($urandom);
    ok = 1;
  endtask

  task automatic send_word(input logic [15:0] w);
    bit ok;
    int low, t;
    accept_only(w, ok);
    if (!ok) return;
    if (m_pix == IMG) begin
      t = 0;
      @(negedge clk);
      while (!done && t < 64) begin
        @(negedge clk);
        t++;
      end
      check("done_at_end", done, 1'b1);
      check("ready_in_done", bus.in_ready, 1'b0);
    end else begin
      low = 0;
      @(negedge clk);
      while (!bus.in_ready && low < 64) begin
        low++;
        @(negedge clk);
      end
      check("occupancy", low, clampf(int'(w[15:8])) + clampf(int'(w[7:0])));
    end
    check("pix_count", pix_count, m_pix);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [15:0] w;
    int k;
    bus.in_valid = 1'b0;
    bus.in_data = '0;

    // reset state
    repeat (3) @(negedge clk);
    RST = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ram_addr", bus.ram_addr, 16'h0000);
    check("rst_ram_data", bus.ram_data, 16'h0000);
    check("rst_pix_count", pix_count, 10'd0);

    // in_valid with the enable rising edge is not accepted
    @(negedge clk);
    enable = 1'b1;
    base_addr = 16'h0100;
    model_start(16'h0100);
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0305;
    #1;
    check("ready_on_enable_edge", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_enable", bus.in_ready, 1'b1);
    check("no_accept_on_edge", pix_count, 10'd0);

    // 0x0305, then 0x0808 and 0x0008
    send_word(16'h0305);
    check("lit_pix_8", pix_count, 10'd8);
    settle();
    check("no_write_yet", wr_log.size(), 0);
    send_word(16'h0808);
    send_word(16'h0008);
    settle();
    check("lit_two_writes", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      check("lit_write0", wr_log[0], 32'h0100_00F8);
      check("lit_write1", wr_log[1], 32'h0101_FFFF);
    end
    check("lit_pix_32", pix_count, 10'd32);
    end_image();

    // 0x1010: zeros word first, then ones
    start_image(16'h0200);
    send_word(16'h1010);
    settle();
    check("lit_1010_writes", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      check("lit_1010_w0", wr_log[0], 32'h0200_0000);
      check("lit_1010_w1", wr_log[1], 32'h0201_FFFF);
    end
    check("lit_1010_err", err, 1'b0);
    end_image();

    // clamp
    start_image(16'h0210);
    send_word(16'h1400);
    check("lit_clamp_err", err, 1'b1);
    check("lit_clamp_pix", pix_count, 10'd16);
    send_word(16'h0001);
    check("lit_after_clamp_pix", pix_count, 10'd17);
    end_image();

    // full image: 25 x 0x1010, last 16 ones dropped
    start_image(16'h0300);
    for (int i = 0; i < 25; i++) send_word(16'h1010);
    check("lit_full_err", err, 1'b1);
    check("lit_full_pix", pix_count, 10'd784);
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0101;
    repeat (5) @(negedge clk);
    check("done_ignores_valid", done, 1'b1);
    bus.in_valid = 1'b0;
    settle();
    check("lit_full_writes", wr_log.size(), 49);
    if (wr_log.size() == 49) begin
      check("lit_full_w47", wr_log[47], 32'h032F_FFFF);
      check("lit_full_w48", wr_log[48], 32'h0330_0000);
    end
    end_image();

    // enable falls mid-run
    start_image(16'h0600);
    accept_only(16'h0410, ok);
    repeat (6) @(negedge clk);
    enable = 1'b0;
    exp_q.delete();
    settle();
    check("abort_no_write", wr_log.size(), 0);
    start_image(16'h0700);
    check("abort_restart_pix", pix_count, 10'd0);
    send_word(16'h0010);
    settle();
    if (wr_log.size() >= 1) check("lit_restart_w0", wr_log[0], 32'h0700_FFFF);
    else check("lit_restart_count", wr_log.size(), 1);
    end_image();

    // RST mid-ONES
    start_image(16'h0400);
    accept_only(16'h0210, ok);
    repeat (4) @(negedge clk);
    RST = 1'b1;
    #1;
    check("arst_in_ready", bus.in_ready, 1'b0);
    check("arst_ram_we", bus.ram_we, 1'b0);
    check("arst_pix", pix_count, 10'd0);
    check("arst_addr_data", {bus.ram_addr, bus.ram_data}, 32'h0);
    check("arst_done_err", {done, err}, 2'b00);
    enable = 1'b0;
    exp_q.delete();
    @(negedge clk);
    RST = 1'b0;
    start_image(16'h0500);
    check("arst_restart_pix", pix_count, 10'd0);
    send_word(16'h1010);
    settle();
    check("arst_writes", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      check("arst_w0", wr_log[0], 32'h0500_0000);
      check("arst_w1", wr_log[1], 32'h0501_FFFF);
    end
    end_image();

    // randomized images
    for (int img = 0; img < 2; img++) begin
      start_image(16'($urandom));
      k = 0;
      while (m_pix < IMG && k < 300) begin
        if ($urandom_range(0, 9) == 0)
          w = {8'($urandom_range(0, 20)), 8'($urandom_range(0, 20))};
        else
          w = {8'($urandom_range(0, 16)), 8'($urandom_range(0, 16))};
        send_word(w);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        k++;
      end
      settle();
      check("rand_done", done, 1'b1);
      check("rand_err", err, m_err);
      check("rand_writes", wr_log.size(), 49);
      end_image();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
